// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-trial engine.
// Holds the trial FSM encoding, S-box depth and the plaintext character filter.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA,
        ST_JUDGE,
        ST_REQ,
        ST_WAIT_KEY,
        ST_FOUND,
        ST_FAIL
    } rc4_state_t;

    localparam int         S_DEPTH    = 256;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;

    // Step counters run down to zero; these are the reload values.
    localparam logic [2:0] KSA_PH_TOP  = 3'd5;
    localparam logic [2:0] PRGA_PH_TOP = 3'd7;

    function automatic logic is_valid_char(input logic [7:0] b);
        return ((b >= CHAR_A) && (b <= CHAR_Z)) || (b == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/rc4_s_mem.sv
// 256x8 single-port RC4 state memory.
// Synchronous write and synchronous read with one cycle of read latency.
module rc4_s_mem
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic [7:0] rdata
);

    logic [7:0] mem [S_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/rc4_key_trial.sv
// RC4 key-trial engine: init, KSA and PRGA per 24-bit candidate key, plaintext filter.
// Build option: define RC4_EARLY_ABORT_EN to reject a key on its first bad plaintext byte.
//
// state       | meaning
// ST_IDLE     | waiting for go
// ST_INIT     | S[i]=i, one write per cycle
// ST_KSA      | key schedule, 6 steps per index
// ST_PRGA     | keystream + decrypt, 8 steps per byte
// ST_JUDGE    | accept or reject the current key
// ST_REQ      | one-cycle key_next pulse
// ST_WAIT_KEY | waiting for key_ack from the counter
// ST_FOUND    | terminal, found_key valid
// ST_FAIL     | terminal, key space exhausted
module rc4_key_trial
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [23:0]       key,
    input  logic              key_ack,
    input  logic              keys_exhausted,
    output logic              key_next,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [7:0]        ct_data,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [7:0]        pt_data,
    output logic              pt_we,
    output logic              busy,
    output logic              found,
    output logic              fail,
    output logic [23:0]       found_key
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

    rc4_state_t state, state_nxt;

    logic [7:0]        i_q, j_q, si_q, sj_q;
    logic [2:0]        ph_q;
    logic [1:0]        kidx_q;
    logic [ADDR_W-1:0] k_q;
    logic              all_ok_q;

    logic [7:0] s_addr, s_wdata, s_rdata;
    logic       s_we;
    logic [7:0] kb;
    logic [7:0] pt_byte;
    logic       byte_ok;
    logic       last_byte;

    rc4_s_mem u_s_mem (
        .clk   (clk),
        .addr  (s_addr),
        .wdata (s_wdata),
        .we    (s_we),
        .rdata (s_rdata)
    );

    assign pt_byte   = s_rdata ^ ct_data;
    assign byte_ok   = is_valid_char(pt_byte);
    assign last_byte = (k_q == K_LAST);

    assign ct_addr   = k_q;
    assign key_next  = (state == ST_REQ);
    assign found     = (state == ST_FOUND);
    assign fail      = (state == ST_FAIL);
    assign busy      = (state != ST_IDLE) && (state != ST_FOUND) && (state != ST_FAIL);

    always_comb begin
        kb = key[7:0];
        case (kidx_q)
            2'd0:    kb = key[23:16];
            2'd1:    kb = key[15:8];
            default: kb = key[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_addr    = i_q;
        s_wdata   = sj_q;
        s_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                s_wdata = i_q;
                s_we    = 1'b1;
                if (i_q == 8'hFF) begin
                    state_nxt = ST_KSA;
                end
            end
            ST_KSA: begin
                case (ph_q)
                    3'd5: s_addr = i_q;
                    3'd3: s_addr = j_q;
                    3'd1: begin
                        s_addr  = i_q;
                        s_wdata = sj_q;
                        s_we    = 1'b1;
                    end
                    3'd0: begin
                        s_addr  = j_q;
                        s_wdata = si_q;
                        s_we    = 1'b1;
                        if (i_q == 8'hFF) begin
                            state_nxt = ST_PRGA;
                        end
                    end
                    default: ;
                endcase
            end
            ST_PRGA: begin
                case (ph_q)
                    3'd7: s_addr = i_q + 8'd1;
                    3'd5: s_addr = j_q;
                    3'd3: begin
                        s_addr  = i_q;
                        s_wdata = sj_q;
                        s_we    = 1'b1;
                    end
                    3'd2: begin
                        s_addr  = j_q;
                        s_wdata = si_q;
                        s_we    = 1'b1;
                    end
                    3'd1: s_addr = si_q + sj_q;
                    3'd0: begin
`ifdef RC4_EARLY_ABORT_EN
                        if (last_byte || !byte_ok) begin
                            state_nxt = ST_JUDGE;
                        end
`else
                        if (last_byte) begin
                            state_nxt = ST_JUDGE;
                        end
`endif
                    end
                    default: ;
                endcase
            end
            ST_JUDGE: begin
                state_nxt = all_ok_q ? ST_FOUND : ST_REQ;
            end
            ST_REQ: begin
                state_nxt = ST_WAIT_KEY;
            end
            ST_WAIT_KEY: begin
                if (key_ack) begin
                    state_nxt = keys_exhausted ? ST_FAIL : ST_INIT;
                end
            end
            ST_FOUND: ;
            ST_FAIL:  ;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            ph_q      <= '0;
            kidx_q    <= '0;
            k_q       <= '0;
            all_ok_q  <= 1'b0;
            pt_we     <= 1'b0;
            pt_addr   <= '0;
            pt_data   <= '0;
            found_key <= '0;
        end else begin
            pt_we <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT_KEY: begin
                    i_q <= '0;
                end
                ST_INIT: begin
                    i_q <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        j_q    <= '0;
                        ph_q   <= KSA_PH_TOP;
                        kidx_q <= '0;
                    end
                end
                ST_KSA: begin
                    if (ph_q == 3'd0) begin
                        i_q    <= i_q + 8'd1;
                        kidx_q <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                        if (i_q == 8'hFF) begin
                            // i wraps to 0 here, which is also the PRGA start value
                            j_q      <= '0;
                            ph_q     <= PRGA_PH_TOP;
                            k_q      <= '0;
                            all_ok_q <= 1'b1;
                        end else begin
                            ph_q <= KSA_PH_TOP;
                        end
                    end else begin
                        ph_q <= ph_q - 3'd1;
                    end
                    if (ph_q == 3'd4) begin
                        si_q <= s_rdata;
                        j_q  <= j_q + s_rdata + kb;
                    end
                    if (ph_q == 3'd2) begin
                        sj_q <= s_rdata;
                    end
                end
                ST_PRGA: begin
                    case (ph_q)
                        3'd7: i_q <= i_q + 8'd1;
                        3'd6: begin
                            si_q <= s_rdata;
                            j_q  <= j_q + s_rdata;
                        end
                        3'd4: sj_q <= s_rdata;
                        3'd0: begin
                            pt_we    <= 1'b1;
                            pt_addr  <= k_q;
                            pt_data  <= pt_byte;
                            all_ok_q <= all_ok_q & byte_ok;
                            if (!last_byte) begin
                                k_q <= k_q + ADDR_W'(1);
                            end
                        end
                        default: ;
                    endcase
                    ph_q <= (ph_q == 3'd0) ? PRGA_PH_TOP : ph_q - 3'd1;
                end
                ST_JUDGE: begin
                    if (all_ok_q) begin
                        found_key <= key;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
